keypad_scan_engine: RTL and testbench

Parametrised successor to the fixed 4x4 keypad front end. It generalises the grid to ROWS x COLS, scans columns, and synchronises the raw row inputs. It debounces both press and release, locks onto a single key (no rollover), and emits a one-cycle key event with a linear key code. An optional auto-repeat mode is included. It feeds the digit-slide and display logic downstream.

---
 rtl/keypad_scan_engine_pkg.sv | 26 ++
 rtl/keypad_scan_engine_row_sync.sv | 24 ++
 rtl/keypad_scan_engine.sv | 162 ++++++++++++++++
 tb/tb_keypad_scan_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_engine_pkg.sv
// Shared types, default timing and width helpers for the keypad scan engine.
// Default timing assumes the ~10 kHz LSOSC clock: 200 cycles is about 20 ms.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_t;

  localparam int DEF_SCAN_DWELL      = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 200;
  localparam int DEF_REPEAT_DELAY    = 5000;
  localparam int DEF_REPEAT_PERIOD   = 1000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return cnt_width(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scan_engine_row_sync.sv
// Two-flop synchroniser for the asynchronous active-low row inputs.
// Resets to all ones so the rows read as released straight out of reset.
module row_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_engine.sv
// Column-scanning keypad front end: press/release debounce, single-key lock,
// one-cycle key events with a linear key code and optional auto-repeat.
module keypad_scan_engine
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DWELL      = DEF_SCAN_DWELL,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CODE_W          = code_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ROWS-1:0]   row_n,
  input  logic              repeat_en,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output scan_state_t       dbg_state
);

  localparam logic [1:0] ST_SCAN     = SCAN;
  localparam logic [1:0] ST_PRESS_DB = PRESS_DB;
  localparam logic [1:0] ST_HELD     = HELD;
  localparam logic [1:0] ST_REL_DB   = REL_DB;

  localparam int CW = cnt_width(COLS);
  localparam int RW = cnt_width(ROWS);
  localparam int DW = cnt_width(SCAN_DWELL);
  localparam int BW = cnt_width(DEBOUNCE_CYCLES);
  localparam int PW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DWELL - 1);
  localparam logic [BW-1:0] DB_LAST     = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] DELAY_LAST  = PW'(REPEAT_DELAY - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(REPEAT_PERIOD - 1);
  localparam logic [PW-1:0] REP_MAX     = '1;

  // key_valid is a single-cycle strobe with no back-pressure: the consumer must
  // take it on the cycle it is high; key_code is stable from that cycle until
  // the next accepted press.
  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [CW-1:0]     col_nxt;
  logic [DW-1:0]     dwell;
  logic [RW-1:0]     row_lat;
  logic [RW-1:0]     low_row;
  logic [BW-1:0]     db_cnt;
  logic [PW-1:0]     rep_cnt;
  logic              rep_armed;
  logic [ROWS-1:0]   row_sync_n;
  logic [ROWS-1:0]   rows;
  logic              row_hit;
  logic [CODE_W-1:0] accept_code;

  row_sync #(.W(ROWS)) u_row_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (row_n),
    .q    (row_sync_n)
  );

  assign rows        = ~row_sync_n;
  assign row_hit     = rows[row_lat];
  assign col_nxt     = (col == COL_LAST) ? '0 : col + CW'(1);
  assign col_n       = ~(COLS'(1) << col);
  assign accept_code = CODE_W'(row_lat) * CODE_W'(COLS) + CODE_W'(col);
  assign dbg_state   = scan_state_t'(state);

  // Lowest-indexed active row wins when several keys share the scanned column.
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (rows[r]) low_row = RW'(r);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_SCAN;
      col       <= '0;
      dwell     <= '0;
      row_lat   <= '0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (|rows) begin
              row_lat <= low_row;
              db_cnt  <= '0;
              state   <= ST_PRESS_DB;
            end else begin
              col <= col_nxt;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        ST_PRESS_DB: begin
          if (!row_hit) begin
            db_cnt <= '0;
            col    <= col_nxt;
            state  <= ST_SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_valid <= 1'b1;
            key_code  <= accept_code;
            key_held  <= 1'b1;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            state     <= ST_HELD;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        ST_HELD: begin
          // rep_cnt measures up to the first repeat, then between repeats.
          if (!row_hit) begin
            db_cnt <= '0;
            state  <= ST_REL_DB;
          end else if (!repeat_en) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
          end else if (rep_cnt == (rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
          end else if (rep_cnt != REP_MAX) begin
            rep_cnt <= rep_cnt + PW'(1);
          end
        end
        ST_REL_DB: begin
          // The repeat counter is left untouched so a bounce resumes it.
          if (row_hit) begin
            state <= ST_HELD;
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            key_held <= 1'b0;
            col      <= col_nxt;
            state    <= ST_SCAN;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_engine.sv
// Bench for keypad_scan_engine: physical keypad model, run-length reference
// model with expected-code queue, directed scenarios and random episodes.
module tb_keypad_scan_engine;
  import keypad_pkg::*;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int DWELL   = 4;
  localparam int DB      = 8;
  localparam int RDELAY  = 40;
  localparam int RPERIOD = 10;
  localparam int CODE_W  = 4;

  localparam int M_LOOKING    = 0;
  localparam int M_CONFIRMING = 1;
  localparam int M_DOWN       = 2;
  localparam int M_LETTING_GO = 3;

  logic                 clk = 1'b0;
  logic                 nrst = 1'b1;
  logic                 repeat_en = 1'b0;
  logic [ROWS-1:0]      row_n;
  logic [COLS-1:0]      col_n;
  logic [CODE_W-1:0]    key_code;
  logic                 key_valid;
  logic                 key_held;
  scan_state_t          dbg_state;
  logic [ROWS*COLS-1:0] key_down = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0] obs_codes[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  keypad_scan_engine #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DWELL(DWELL), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clk(clk), .nrst(nrst), .row_n(row_n), .repeat_en(repeat_en),
    .col_n(col_n), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .dbg_state(dbg_state)
  );

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_n[r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (key_down[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                m_col, m_t, m_mode, m_row, m_run, m_held_t;
  logic [ROWS-1:0]   m_s1, m_s2;
  logic              exp_valid, exp_held;
  logic [CODE_W-1:0] exp_code;

  function automatic logic [ROWS-1:0] phys_rows(input int col);
    logic [ROWS-1:0] v;
    v = '1;
    for (int r = 0; r < ROWS; r++) if (key_down[r*COLS+col]) v[r] = 1'b0;
    return v;
  endfunction

  always @(posedge clk or negedge nrst) begin : model
    logic [ROWS-1:0] act;
    if (!nrst) begin
      m_col = 0; m_t = 0; m_mode = M_LOOKING; m_row = 0; m_run = 0; m_held_t = 0;
      m_s1 = '1; m_s2 = '1;
      exp_valid = 1'b0; exp_held = 1'b0; exp_code = '0;
    end else begin
      act  = ~m_s2;
      m_s2 = m_s1;
      m_s1 = phys_rows(m_col);
      exp_valid = 1'b0;
      case (m_mode)
        M_LOOKING: begin
          if (m_t == DWELL - 1) begin
            m_t = 0;
            if (act != 0) begin
              m_row = ROWS;
              for (int r = ROWS - 1; r >= 0; r--) if (act[r]) m_row = r;
              m_run  = 1;
              m_mode = M_CONFIRMING;
            end else m_col = (m_col + 1) % COLS;
          end else m_t++;
        end
        M_CONFIRMING: begin
          if (act[m_row]) begin
            m_run++;
            if (m_run == DB + 1) begin
              exp_valid = 1'b1; exp_held = 1'b1;
              exp_code  = CODE_W'(m_row * COLS + m_col);
              exp_q.push_back(exp_code);
              m_held_t = 0;
              m_mode   = M_DOWN;
            end
          end else begin
            m_col = (m_col + 1) % COLS; m_t = 0; m_mode = M_LOOKING;
          end
        end
        M_DOWN: begin
          if (!act[m_row]) begin
            m_run = 1; m_mode = M_LETTING_GO;
          end else if (repeat_en) begin
            m_held_t++;
            if (m_held_t >= RDELAY && (m_held_t - RDELAY) % RPERIOD == 0) begin
              exp_valid = 1'b1;
              exp_q.push_back(exp_code);
            end
          end else m_held_t = 0;
        end
        default: begin
          if (act[m_row]) m_mode = M_DOWN;
          else begin
            m_run++;
            if (m_run == DB + 1) begin
              exp_held = 1'b0; m_col = (m_col + 1) % COLS; m_t = 0; m_mode = M_LOOKING;
            end
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin : monitor
    logic [COLS-1:0] exp_col;
    if (nrst) begin
      exp_col = ~(COLS'(1) << m_col);
      check("key_valid", key_valid, exp_valid);
      check("key_held", key_held, exp_held);
      check("key_code", key_code, exp_code);
      check("col_n", col_n, exp_col);
      if (key_valid) begin
        obs_codes.push_back(key_code);
        if (exp_q.size() == 0) check("pulse_pending", exp_q.size(), 1);
        else check("pulse_code", key_code, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) break;
    end
    if (i == budget) check(tag, key_valid, 1);
  endtask

  task automatic check_scen(input string tag, input int n_exp, input logic [CODE_W-1:0] code);
    check({tag, "_count"}, obs_codes.size(), n_exp);
    foreach (obs_codes[i]) check({tag, "_code"}, obs_codes[i], code);
    obs_codes.delete();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int i;
    logic [ROWS*COLS-1:0] mask;
    int k1, k2, hold;

    // reset state
    #1 nrst = 1'b0;
    #1;
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    tick(3);
    nrst = 1'b1;
    tick(5);

    // 1: clean press of key 9, no repeat
    key_down[9] = 1'b1;
    tick(100);
    key_down[9] = 1'b0;
    tick(2);
    check("s1_held_after_release", key_held, 1);
    tick(40);
    check("s1_released", key_held, 0);
    check_scen("s1", 1, 4'd9);

    // 2: bouncing press of key 3
    for (int b = 0; b < 5; b++) begin
      key_down[3] = 1'b1; tick(3);
      key_down[3] = 1'b0; tick(3);
    end
    check("s2_bounce_silent", obs_codes.size(), 0);
    key_down[3] = 1'b1;
    wait_pulse("s2_timeout", 100);
    tick(20);
    key_down[3] = 1'b0;
    tick(40);
    check_scen("s2", 1, 4'd3);

    // 3: bouncing release of key 5
    key_down[5] = 1'b1;
    wait_pulse("s3_timeout", 100);
    tick(20);
    for (int b = 0; b < 4; b++) begin
      key_down[5] = 1'b0; tick(3);
      key_down[5] = 1'b1; tick(3);
    end
    check("s3_held_through_glitches", key_held, 1);
    key_down[5] = 1'b0;
    tick(40);
    check("s3_released", key_held, 0);
    check_scen("s3", 1, 4'd5);

    // 4: auto-repeat on key 15
    repeat_en = 1'b1;
    key_down[15] = 1'b1;
    wait_pulse("s4_timeout", 100);
    tick(95);
    key_down[15] = 1'b0;
    tick(40);
    repeat_en = 1'b0;
    check_scen("s4", 7, 4'd15);

    // 5: no rollover, key 14 waits for key 4 to release
    key_down[4] = 1'b1;
    wait_pulse("s5_first_timeout", 100);
    key_down[14] = 1'b1;
    tick(60);
    check("s5_no_early_pulse", obs_codes.size(), 1);
    key_down[4] = 1'b0;
    wait_pulse("s5_second_timeout", 100);
    tick(30);
    key_down[14] = 1'b0;
    tick(40);
    check("s5_count", obs_codes.size(), 2);
    if (obs_codes.size() == 2) begin
      check("s5_first", obs_codes[0], 4);
      check("s5_second", obs_codes[1], 14);
    end
    obs_codes.delete();

    // 6: reset during press debounce
    key_down[6] = 1'b1;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_mode == M_CONFIRMING) break;
    end
    check("s6_reach_confirm", m_mode, M_CONFIRMING);
    tick(2);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("s6_col_n", col_n, 4'b1110);
    check("s6_key_valid", key_valid, 0);
    check("s6_key_held", key_held, 0);
    check("s6_key_code", key_code, 0);
    check("s6_state", dbg_state, SCAN);
    key_down[6] = 1'b0;
    tick(3);
    nrst = 1'b1;
    tick(30);
    check_scen("s6", 0, 4'd0);

    // 7: random episodes, checked cycle by cycle against the model
    for (int e = 0; e < 25; e++) begin
      repeat_en = 1'($urandom_range(0, 1));
      k1 = $urandom_range(0, ROWS*COLS - 1);
      k2 = (((k1 / COLS) + 1 + $urandom_range(0, ROWS - 2)) % ROWS) * COLS + (k1 % COLS);
      mask = '0;
      mask[k1] = 1'b1;
      if ($urandom_range(0, 3) == 0) mask[k2] = 1'b1;
      for (int b = $urandom_range(0, 4); b > 0; b--) begin
        key_down = mask; tick($urandom_range(1, 4));
        key_down = '0;   tick($urandom_range(1, 4));
      end
      key_down = mask;
      hold = $urandom_range(0, 120);
      tick(hold);
      for (int b = $urandom_range(0, 3); b > 0; b--) begin
        key_down = '0;   tick($urandom_range(1, 4));
        key_down = mask; tick($urandom_range(1, 4));
      end
      key_down = '0;
      tick($urandom_range(20, 40));
    end
    repeat_en = 1'b0;
    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
